// File: rtl/pc_fetch_unit_if.sv
// Fetch-unit bus bundle: branch redirect, instruction-memory request/response
// and the decode-side valid/ready handshake.
// master = fetch unit, slave = surrounding pipeline / memory.
interface pc_fetch_unit_if;
   logic        take_branch;
   logic [63:0] branch_target;
   logic        imem_req_valid;
   logic [63:0] imem_req_addr;
   logic        imem_req_ready;
   logic        imem_resp_valid;
   logic [31:0] imem_resp_data;
   logic        inst_valid;
   logic [31:0] inst;
   logic [63:0] inst_pc;
   logic        inst_ready;

   modport master (
      input  take_branch, branch_target, imem_req_ready, imem_resp_valid,
             imem_resp_data, inst_ready,
      output imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
   );

   modport slave (
      output take_branch, branch_target, imem_req_ready, imem_resp_valid,
             imem_resp_data, inst_ready,
      input  imem_req_valid, imem_req_addr, inst_valid, inst, inst_pc
   );
endinterface

// File: rtl/pc_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps at most one imem request in
// flight, hands fetched words to decode and redirects on taken branches,
// squashing wrong-path responses or held instructions.
// Optional macro FETCH_PERF_EN adds perf_fetched / perf_squashed counters.
module pc_fetch_unit #(
   parameter logic [63:0] RESET_PC = 64'h0,
   parameter int unsigned PC_STEP  = 4
) (
   input  logic              clk,
   input  logic              reset,
   pc_fetch_unit_if.master   fbus,
   output logic              fetch_fault
`ifdef FETCH_PERF_EN
   ,
   output logic [63:0]       perf_fetched,
   output logic [63:0]       perf_squashed
`endif
);

   localparam logic [63:0] STEP = 64'(PC_STEP);

   typedef enum logic [1:0] {
      S_REQ  = 2'd0,
      S_WAIT = 2'd1,
      S_HOLD = 2'd2,
      S_HALT = 2'd3
   } state_t;

   state_t      state_q, state_d;
   logic [63:0] pc_q, pc_d;
   logic        squash_q, squash_d;
   logic [31:0] inst_q, inst_d;
   logic [63:0] inst_pc_q, inst_pc_d;
   logic        fault_q, fault_d;

   logic        redirect_s;
   logic        misaligned_s;
   logic        accept_s;

   assign redirect_s   = fbus.take_branch && (fbus.branch_target[1:0] == 2'b00);
   assign misaligned_s = fbus.take_branch && (fbus.branch_target[1:0] != 2'b00);
   assign accept_s     = (state_q == S_REQ) && fbus.imem_req_ready;

   // State, PC and held-instruction registers.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= S_REQ;
         pc_q      <= RESET_PC;
         squash_q  <= 1'b0;
         inst_q    <= 32'h0;
         inst_pc_q <= 64'h0;
         fault_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         squash_q  <= squash_d;
         inst_q    <= inst_d;
         inst_pc_q <= inst_pc_d;
         fault_q   <= fault_d;
      end
   end

   // Next-state logic; a redirect outranks every other event in the cycle.
   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      squash_d  = squash_q;
      inst_d    = inst_q;
      inst_pc_d = inst_pc_q;
      fault_d   = fault_q;

      case (state_q)
         S_REQ: begin
            if (misaligned_s) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else if (redirect_s) begin
               pc_d = fbus.branch_target;
               if (accept_s) begin
                  // The request just issued is on the wrong path.
                  state_d  = S_WAIT;
                  squash_d = 1'b1;
               end else begin
                  state_d = S_REQ;
               end
            end else if (accept_s) begin
               state_d = S_WAIT;
            end else begin
               state_d = S_REQ;
            end
         end

         S_WAIT: begin
            if (misaligned_s) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else if (redirect_s) begin
               pc_d = fbus.branch_target;
               if (fbus.imem_resp_valid) begin
                  // Response arriving now is stale; refetch immediately.
                  squash_d = 1'b0;
                  state_d  = S_REQ;
               end else begin
                  squash_d = 1'b1;
                  state_d  = S_WAIT;
               end
            end else if (fbus.imem_resp_valid) begin
               if (squash_q) begin
                  squash_d = 1'b0;
                  state_d  = S_REQ;
               end else begin
                  inst_d    = fbus.imem_resp_data;
                  inst_pc_d = pc_q;
                  state_d   = S_HOLD;
               end
            end else begin
               state_d = S_WAIT;
            end
         end

         S_HOLD: begin
            if (misaligned_s) begin
               fault_d = 1'b1;
               state_d = S_HALT;
            end else if (redirect_s) begin
               // Same-cycle consume still happens, but the next PC is the target.
               pc_d    = fbus.branch_target;
               state_d = S_REQ;
            end else if (fbus.inst_ready) begin
               pc_d    = pc_q + STEP;
               state_d = S_REQ;
            end else begin
               state_d = S_HOLD;
            end
         end

         S_HALT: begin
            state_d = S_HALT;
         end

         default: begin
            state_d = S_HALT;
            fault_d = 1'b1;
         end
      endcase
   end

   assign fbus.imem_req_valid = (state_q == S_REQ) && !reset;
   assign fbus.imem_req_addr  = pc_q;
   assign fbus.inst_valid     = (state_q == S_HOLD) && !reset;
   assign fbus.inst           = inst_q;
   assign fbus.inst_pc        = inst_pc_q;
   assign fetch_fault         = fault_q;

`ifdef FETCH_PERF_EN
   logic        fetched_inc_s;
   logic        squashed_inc_s;
   logic [63:0] perf_fetched_q;
   logic [63:0] perf_squashed_q;

   // Event decode: consumes, discarded responses and dropped held words.
   always_comb begin
      fetched_inc_s  = (state_q == S_HOLD) && fbus.inst_ready;
      squashed_inc_s = ((state_q == S_WAIT) && fbus.imem_resp_valid &&
                        (squash_q || fbus.take_branch)) ||
                       ((state_q == S_HOLD) && fbus.take_branch && !fbus.inst_ready);
   end

   // Free-running wrap-around performance counters.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         perf_fetched_q  <= 64'h0;
         perf_squashed_q <= 64'h0;
      end else begin
         perf_fetched_q  <= perf_fetched_q + (fetched_inc_s ? 64'd1 : 64'd0);
         perf_squashed_q <= perf_squashed_q + (squashed_inc_s ? 64'd1 : 64'd0);
      end
   end

   assign perf_fetched  = perf_fetched_q;
   assign perf_squashed = perf_squashed_q;
`endif

endmodule

// File: tb/tb_pc_fetch_unit.sv
// Bench for pc_fetch_unit: directed vector table, hand-written reset
// sequences, then randomized traffic against an address-stream model.
module tb_pc_fetch_unit;

   logic clk;
   logic reset;
   logic fetch_fault;
`ifdef FETCH_PERF_EN
   logic [63:0] perf_fetched;
   logic [63:0] perf_squashed;
`endif

   pc_fetch_unit_if bus ();

   pc_fetch_unit dut (
      .clk         (clk),
      .reset       (reset),
      .fbus        (bus),
      .fetch_fault (fetch_fault)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetched  (perf_fetched),
      .perf_squashed (perf_squashed)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Memory contents: a fixed function of the address.
   function automatic logic [31:0] mem_word(input logic [63:0] addr);
      return addr[31:0] ^ addr[63:32] ^ 32'h1357_9BDF;
   endfunction

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   typedef struct {
      logic        rdy;
      logic        rv;
      logic [31:0] rd;
      logic        ir;
      logic        tb;
      logic [63:0] tgt;
      logic        e_rv;
      logic [63:0] e_addr;
      logic        e_iv;
      logic [63:0] e_ipc;
      logic        e_flt;
      int          e_sq;
   } vec_t;

   vec_t vecs[$];

   function automatic void add_vec(input logic rdy, input logic rv, input logic [31:0] rd,
                                   input logic ir, input logic tb, input logic [63:0] tgt,
                                   input logic e_rv, input logic [63:0] e_addr,
                                   input logic e_iv, input logic [63:0] e_ipc,
                                   input logic e_flt, input int e_sq);
      vec_t v;
      v.rdy = rdy; v.rv = rv; v.rd = rd; v.ir = ir; v.tb = tb; v.tgt = tgt;
      v.e_rv = e_rv; v.e_addr = e_addr; v.e_iv = e_iv; v.e_ipc = e_ipc;
      v.e_flt = e_flt; v.e_sq = e_sq;
      vecs.push_back(v);
   endfunction

   task automatic drive(input logic rdy, input logic rv, input logic [31:0] rd,
                        input logic ir, input logic tb, input logic [63:0] tgt);
      bus.imem_req_ready  = rdy;
      bus.imem_resp_valid = rv;
      bus.imem_resp_data  = rd;
      bus.inst_ready      = ir;
      bus.take_branch     = tb;
      bus.branch_target   = tgt;
   endtask

   task automatic check_idle_outputs(input string tag);
      check({tag, " req_valid"}, {63'h0, bus.imem_req_valid}, 64'h0);
      check({tag, " inst_valid"}, {63'h0, bus.inst_valid}, 64'h0);
      check({tag, " fetch_fault"}, {63'h0, fetch_fault}, 64'h0);
   endtask

   // Watchdog: the run must never hang.
   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail + 1);
      $fatal(1, "timeout");
   end

   // Main stimulus.
   initial begin
      logic [63:0] a;
      logic [63:0] exp_next;
      logic [63:0] oaddr;
      logic        outst;
      int          cd;
      logic        halted;
      int          halt_cnt;
      int          idle;
      logic        s_rqv, s_iv;
      logic [63:0] s_addr, s_ipc;
      logic [31:0] s_inst;
      logic        s_flt;
      logic        d_rdy, d_rv, d_ir, d_tb;
      logic [31:0] d_rd;
      logic [63:0] d_tgt;
      int          r;

      // ---------------- vector table ----------------
      for (int k = 0; k < 8; k++) begin
         a = 64'(4 * k);
         if (a == 64'h10) begin
            for (int s = 0; s < 5; s++)
               add_vec(1'b0, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, a, 1'b0, 64'h0, 1'b0, -1);
         end
         add_vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, -1);
         add_vec(1'b1, 1'b1, mem_word(a), 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, a, 1'b0, -1);
         add_vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b1, a + 64'd4, 1'b0, 64'h0, 1'b0, -1);
      end
      // Redirect while waiting on 0x20: its response must be discarded.
      add_vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 0);
      add_vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 64'h100, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 0);
      add_vec(1'b1, 1'b1, mem_word(64'h20), 1'b1, 1'b0, 64'h0, 1'b1, 64'h100, 1'b0, 64'h0, 1'b0, 1);
      // Fetch 0x100, hold it unconsumed, then drop it with a redirect to 0x40.
      add_vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 1);
      add_vec(1'b1, 1'b1, mem_word(64'h100), 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h100, 1'b0, 1);
      add_vec(1'b1, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h100, 1'b0, 1);
      add_vec(1'b1, 1'b0, 32'h0, 1'b0, 1'b1, 64'h40, 1'b1, 64'h40, 1'b0, 64'h0, 1'b0, 2);
      // Hold 0x40, consume and redirect to 0x80 in the same cycle.
      add_vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 64'h0, 1'b0, 2);
      add_vec(1'b1, 1'b1, mem_word(64'h40), 1'b1, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 64'h40, 1'b0, 2);
      add_vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 64'h80, 1'b1, 64'h80, 1'b0, 64'h0, 1'b0, 2);
      // Misaligned redirect: sticky fault, halted regardless of later activity.
      add_vec(1'b1, 1'b0, 32'h0, 1'b1, 1'b1, 64'h102, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 2);
      for (int s = 0; s < 4; s++)
         add_vec(1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1, 1'b1, 64'h200, 1'b0, 64'h0, 1'b0, 64'h0, 1'b1, 2);

      // ---------------- reset state ----------------
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      reset = 1'b1;
      #1;
      check_idle_outputs("reset");
      check("reset inst", {32'h0, bus.inst}, 64'h0);
      check("reset inst_pc", bus.inst_pc, 64'h0);
      repeat (2) @(negedge clk);
      reset = 1'b0;
      #1;
      check("release req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
      check("release req_addr", bus.imem_req_addr, 64'h0);

      // ---------------- table loop ----------------
      for (int i = 0; i < vecs.size(); i++) begin
         @(negedge clk);
         drive(vecs[i].rdy, vecs[i].rv, vecs[i].rd, vecs[i].ir, vecs[i].tb, vecs[i].tgt);
         @(posedge clk);
         #1;
         check($sformatf("vec%0d req_valid", i), {63'h0, bus.imem_req_valid}, {63'h0, vecs[i].e_rv});
         if (vecs[i].e_rv)
            check($sformatf("vec%0d req_addr", i), bus.imem_req_addr, vecs[i].e_addr);
         check($sformatf("vec%0d inst_valid", i), {63'h0, bus.inst_valid}, {63'h0, vecs[i].e_iv});
         if (vecs[i].e_iv) begin
            check($sformatf("vec%0d inst_pc", i), bus.inst_pc, vecs[i].e_ipc);
            check($sformatf("vec%0d inst", i), {32'h0, bus.inst}, {32'h0, mem_word(vecs[i].e_ipc)});
         end
         check($sformatf("vec%0d fetch_fault", i), {63'h0, fetch_fault}, {63'h0, vecs[i].e_flt});
`ifdef FETCH_PERF_EN
         if (vecs[i].e_sq >= 0)
            check($sformatf("vec%0d perf_squashed", i), perf_squashed, 64'(vecs[i].e_sq));
`endif
      end

      // ---------------- reset out of halt ----------------
      @(negedge clk);
      drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
      reset = 1'b1;
      #1;
      check_idle_outputs("halt reset");
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("halt restart req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
      check("halt restart addr", bus.imem_req_addr, 64'h0);

      // ---------------- async reset while waiting ----------------
      @(negedge clk);
      drive(1'b1, 1'b0, 32'h0, 1'b1, 1'b0, 64'h0);
      @(posedge clk);
      #1;
      check("pre-reset wait req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
      #2;
      reset = 1'b1;
      drive(1'b0, 1'b1, mem_word(64'h0), 1'b1, 1'b0, 64'h0);
      #1;
      check("async reset req_valid", {63'h0, bus.imem_req_valid}, 64'h0);
      check("async reset inst_valid", {63'h0, bus.inst_valid}, 64'h0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("wait reset req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
      check("wait reset addr", bus.imem_req_addr, 64'h0);
      @(posedge clk);
      #1;
      check("stale resp inst_valid", {63'h0, bus.inst_valid}, 64'h0);
      check("stale resp req_valid", {63'h0, bus.imem_req_valid}, 64'h1);
      check("stale resp addr", bus.imem_req_addr, 64'h0);

      // ---------------- randomized traffic ----------------
      exp_next = 64'h0;
      outst    = 1'b0;
      oaddr    = 64'h0;
      cd       = 0;
      halted   = 1'b0;
      halt_cnt = 0;
      idle     = 0;
      for (int cyc = 0; cyc < 4000; cyc++) begin
         @(negedge clk);
         d_rv = 1'b0;
         d_rd = 32'h0;
         if (outst && cd == 0) begin
            d_rv = 1'b1;
            d_rd = mem_word(oaddr);
         end else if (!outst && ($urandom % 10 == 0)) begin
            d_rv = 1'b1;
            d_rd = $urandom;
         end
         d_rdy = ($urandom % 4) != 0;
         d_ir  = ($urandom % 4) != 0;
         d_tb  = 1'b0;
         d_tgt = 64'h0;
         if ($urandom % 16 == 0) begin
            d_tb = 1'b1;
            r = $urandom % 8;
            if (r == 0)
               d_tgt = {$urandom, $urandom} | 64'h2;
            else if (r == 1)
               d_tgt = 64'hFFFF_FFFF_FFFF_FFF8;
            else
               d_tgt = {$urandom, $urandom} & ~64'h3;
         end
         drive(d_rdy, d_rv, d_rd, d_ir, d_tb, d_tgt);
         #1;
         s_rqv  = bus.imem_req_valid;
         s_addr = bus.imem_req_addr;
         s_iv   = bus.inst_valid;
         s_ipc  = bus.inst_pc;
         s_inst = bus.inst;
         s_flt  = fetch_fault;
         if (halted) begin
            check("rnd halted fault", {63'h0, s_flt}, 64'h1);
            check("rnd halted req_valid", {63'h0, s_rqv}, 64'h0);
            check("rnd halted inst_valid", {63'h0, s_iv}, 64'h0);
         end else begin
            check("rnd fault", {63'h0, s_flt}, 64'h0);
            if (s_rqv) begin
               check("rnd req_addr", s_addr, exp_next);
               check("rnd single outstanding", {63'h0, outst}, 64'h0);
            end
            if (s_iv) begin
               check("rnd inst_pc", s_ipc, exp_next);
               check("rnd inst", {32'h0, s_inst}, {32'h0, mem_word(exp_next)});
            end
         end
         @(posedge clk);
         if (d_rv && outst)
            outst = 1'b0;
         else if (outst)
            cd--;
         if (!halted) begin
            if (s_rqv && d_rdy) begin
               outst = 1'b1;
               cd    = $urandom % 4;
               oaddr = s_addr;
            end
            if (s_iv && d_ir)
               idle = 0;
            else
               idle++;
            if (idle > 300) begin
               check("rnd progress", 64'(idle), 64'd0);
               idle = 0;
            end
            if (d_tb) begin
               if (d_tgt[1:0] != 2'b00)
                  halted = 1'b1;
               else
                  exp_next = d_tgt;
            end else if (s_iv && d_ir) begin
               exp_next = exp_next + 64'd4;
            end
         end else begin
            halt_cnt++;
            if (halt_cnt == 4) begin
               @(negedge clk);
               drive(1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 64'h0);
               reset = 1'b1;
               #1;
               check_idle_outputs("rnd reset");
               @(negedge clk);
               reset    = 1'b0;
               exp_next = 64'h0;
               outst    = 1'b0;
               halted   = 1'b0;
               halt_cnt = 0;
               idle     = 0;
            end
         end
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
